// File: rtl/lcd_scroll_ctrl.sv
// HD44780-style 8-bit write-only character LCD controller: power-up init,
// continuous refresh of a ROWS x COLS character buffer, run-time horizontal scroll.
module lcd_scroll_ctrl #(
    parameter int CLK_DIV         = 5,
    parameter int COLS            = 16,
    parameter int ROWS            = 2,
    parameter int POWERUP_SLOTS   = 70,
    parameter int CLEAR_SLOTS     = 20,
    parameter int FRAME_GAP_SLOTS = 30,
    parameter int SCROLL_FRAMES   = 50,
    localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          scroll_en,
    input  logic          scroll_dir,
    output logic          e,
    output logic          rs,
    output logic          rw,
    output logic [7:0]    data,
    output logic          ready,
    output logic          frame_done
);

    localparam int DEPTH   = ROWS * COLS;
    localparam int OW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW      = $clog2(SCROLL_FRAMES + 1);
    localparam int MAX_A   = (POWERUP_SLOTS > CLEAR_SLOTS) ? POWERUP_SLOTS : CLEAR_SLOTS;
    localparam int MAX_B   = (FRAME_GAP_SLOTS > COLS) ? FRAME_GAP_SLOTS : COLS;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_SLOTS - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_SLOTS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(FRAME_GAP_SLOTS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [1:0]    ROW_LAST = 2'(ROWS - 1);
    localparam logic [7:0]    FUNC_CMD = (ROWS > 1) ? 8'h38 : 8'h30;

    typedef enum logic [3:0] {
        INIT_WAIT,
        FUNC_SET,
        DISP_ON,
        ENTRY,
        CLEAR,
        CLEAR_WAIT,
        ROW_ADDR,
        ROW_CHARS,
        FRAME_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    row, row_nxt;
    logic          rs_nxt, rw_nxt;
    logic [7:0]    data_nxt;

    logic [DW-1:0] div;
    logic          div_last;
    logic          slot_start;
    logic          frame_start;
    logic [OW-1:0] ofs;
    logic [FW-1:0] frame_cnt;

    logic [7:0]    char_mem [DEPTH];
    logic [OW:0]   col_sum;
    logic [OW-1:0] col_idx;
    logic [AW-1:0] rd_addr;
    logic [7:0]    row_base;

    assign div_last   = (div == DW'(CLK_DIV - 1));
    assign slot_start = div_last && !e;
    // The state register always describes the slot about to start, so ready
    // and frame_done line up with the clk where ROW_ADDR(0) begins.
    assign frame_start = slot_start && (state == ROW_ADDR) && (row == 2'd0) && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            e   <= 1'b0;
        end else if (div_last) begin
            div <= '0;
            e   <= ~e;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        col_sum = {1'b0, cnt[OW-1:0]} + {1'b0, ofs};
        col_idx = (col_sum >= (OW+1)'(COLS)) ? OW'(col_sum - (OW+1)'(COLS)) : col_sum[OW-1:0];
        rd_addr = AW'(int'(row) * COLS + int'(col_idx));
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(COLS);
            default: row_base = 8'(8'h40 + COLS);
        endcase
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        rs_nxt    = 1'b1;
        rw_nxt    = 1'b1;
        data_nxt  = 8'h00;
        case (state)
            INIT_WAIT: begin
                if (cnt == PWR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = FUNC_SET;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FUNC_SET: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                data_nxt  = FUNC_CMD;
                state_nxt = DISP_ON;
            end
            DISP_ON: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                data_nxt  = 8'h0C;
                state_nxt = ENTRY;
            end
            ENTRY: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                data_nxt  = 8'h06;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                data_nxt  = 8'h01;
                state_nxt = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                if (cnt == CLR_LAST) begin
                    cnt_nxt   = '0;
                    row_nxt   = 2'd0;
                    state_nxt = ROW_ADDR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ROW_ADDR: begin
                rs_nxt    = 1'b0;
                rw_nxt    = 1'b0;
                data_nxt  = 8'h80 | row_base;
                cnt_nxt   = '0;
                state_nxt = ROW_CHARS;
            end
            ROW_CHARS: begin
                rw_nxt   = 1'b0;
                data_nxt = char_mem[rd_addr];
                if (cnt == COL_LAST) begin
                    cnt_nxt = '0;
                    if (row == ROW_LAST) begin
                        state_nxt = FRAME_GAP;
                    end else begin
                        row_nxt   = row + 1'b1;
                        state_nxt = ROW_ADDR;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FRAME_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    row_nxt   = 2'd0;
                    state_nxt = ROW_ADDR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT_WAIT;
            cnt   <= '0;
            row   <= 2'd0;
            rs    <= 1'b1;
            rw    <= 1'b1;
            data  <= 8'h00;
        end else if (slot_start) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
            rs    <= rs_nxt;
            rw    <= rw_nxt;
            data  <= data_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ofs        <= '0;
            frame_cnt  <= '0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            if (slot_start && (state == ROW_ADDR) && (row == 2'd0))
                ready <= 1'b1;
            if (frame_start) begin
                if (!scroll_en) begin
                    frame_cnt <= '0;
                end else if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    if (!scroll_dir)
                        ofs <= (ofs == OW'(COLS - 1)) ? '0 : ofs + 1'b1;
                    else
                        ofs <= (ofs == '0) ? OW'(COLS - 1) : ofs - 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: the buffer must come up as spaces, so it is a reset register file, not a RAM.
    // A write on the edge a data slot reads the same byte sends the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                char_mem[i] <= 8'h20;
        end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
            char_mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lcd_scroll_ctrl.sv
// Self-checking bench for lcd_scroll_ctrl: a time-indexed slot model predicts
// every output each clk while directed and random writes/scroll settings are applied.
module tb_lcd_scroll_ctrl;

    localparam int CLK_DIV         = 2;
    localparam int COLS            = 16;
    localparam int ROWS            = 2;
    localparam int POWERUP_SLOTS   = 4;
    localparam int CLEAR_SLOTS     = 2;
    localparam int FRAME_GAP_SLOTS = 3;
    localparam int SCROLL_FRAMES   = 2;

    localparam int DEPTH  = ROWS * COLS;
    localparam int AW     = $clog2(DEPTH);
    localparam int SLOT   = 2 * CLK_DIV;
    localparam int FL     = ROWS * (COLS + 1) + FRAME_GAP_SLOTS;
    localparam int S0     = POWERUP_SLOTS + 4 + CLEAR_SLOTS;
    localparam int FRAME_CLKS = FL * SLOT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          scroll_en = 1'b0;
    logic          scroll_dir = 1'b0;
    logic          e, rs, rw, ready, frame_done;
    logic [7:0]    data;

    lcd_scroll_ctrl #(
        .CLK_DIV(CLK_DIV), .COLS(COLS), .ROWS(ROWS),
        .POWERUP_SLOTS(POWERUP_SLOTS), .CLEAR_SLOTS(CLEAR_SLOTS),
        .FRAME_GAP_SLOTS(FRAME_GAP_SLOTS), .SCROLL_FRAMES(SCROLL_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_en(scroll_en), .scroll_dir(scroll_dir), .e(e), .rs(rs), .rw(rw),
        .data(data), .ready(ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: t counts clk edges since reset release.
    int         t;
    logic [7:0] mem_m [DEPTH];
    int         ofs_m, fcnt_m, last_fd_t;
    logic       exp_rs, exp_rw, exp_ready;
    logic [7:0] exp_data;
    logic [7:0] init_cmd [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h20;
        ofs_m     = 0;
        fcnt_m    = 0;
        last_fd_t = -1;
        exp_rs    = 1'b1;
        exp_rw    = 1'b1;
        exp_data  = 8'h00;
        exp_ready = 1'b0;
        t         = 0;
    endtask

    // Position within the frame of a slot starting on edge tt, or -1.
    function automatic int slot_pos(input int tt);
        int n;
        if (tt < CLK_DIV || (tt % SLOT) != CLK_DIV) return -1;
        n = (tt - CLK_DIV) / SLOT;
        if (n < S0) return -1;
        return (n - S0) % FL;
    endfunction

    // Buffer address a data slot starting on edge tt reads, or -1.
    function automatic int sampled_addr(input int tt);
        int pos, j;
        pos = slot_pos(tt);
        if (pos < 0 || pos >= ROWS * (COLS + 1)) return -1;
        j = pos % (COLS + 1);
        if (j == 0) return -1;
        return (pos / (COLS + 1)) * COLS + (j - 1 + ofs_m) % COLS;
    endfunction

    task automatic monitor();
        logic fd_exp;
        int   n, k, pos, r, j;
        fd_exp = 1'b0;
        if (t >= CLK_DIV && (t % SLOT) == CLK_DIV) begin
            n = (t - CLK_DIV) / SLOT;
            exp_rs   = 1'b1;
            exp_rw   = 1'b1;
            exp_data = 8'h00;
            if (n >= POWERUP_SLOTS && n < POWERUP_SLOTS + 4) begin
                exp_rs   = 1'b0;
                exp_rw   = 1'b0;
                exp_data = init_cmd[n - POWERUP_SLOTS];
            end else if (n >= S0) begin
                k   = n - S0;
                pos = k % FL;
                if (pos == 0) begin
                    exp_ready = 1'b1;
                    if (k >= FL) begin
                        fd_exp = 1'b1;
                        if (!scroll_en) begin
                            fcnt_m = 0;
                        end else begin
                            fcnt_m++;
                            if (fcnt_m == SCROLL_FRAMES) begin
                                fcnt_m = 0;
                                ofs_m  = scroll_dir ? (ofs_m + COLS - 1) % COLS : (ofs_m + 1) % COLS;
                            end
                        end
                    end
                end
                if (pos < ROWS * (COLS + 1)) begin
                    r = pos / (COLS + 1);
                    j = pos % (COLS + 1);
                    exp_rw = 1'b0;
                    if (j == 0) begin
                        exp_rs   = 1'b0;
                        exp_data = 8'h80 | ((r % 2 == 1) ? 8'h40 : 8'h00) | ((r >= 2) ? 8'(COLS) : 8'h00);
                    end else begin
                        exp_data = mem_m[r * COLS + (j - 1 + ofs_m) % COLS];
                    end
                end
            end
        end
        check("e", e, 32'((t / CLK_DIV) % 2));
        check("rs", rs, exp_rs);
        check("rw", rw, exp_rw);
        check("data", data, exp_data);
        check("ready", ready, exp_ready);
        check("frame_done", frame_done, fd_exp);
        if (frame_done) begin
            if (last_fd_t >= 0) check("fd_period", t - last_fd_t, FRAME_CLKS);
            last_fd_t = t;
        end
        // The write held across this edge lands after the edge's data slot sampled.
        if (wr_en && int'(wr_addr) < DEPTH) mem_m[wr_addr] = wr_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!reset) begin
            t++;
            monitor();
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic write_char(input int addr, input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = ch;
        step();
        wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_e"}, e, 0);
        check({tag, "_rs"}, rs, 1);
        check({tag, "_rw"}, rw, 1);
        check({tag, "_data"}, data, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fd"}, frame_done, 0);
    endtask

    task automatic wait_addr(input int addr, input string tag);
        int budget;
        budget = 2 * FRAME_CLKS;
        while (sampled_addr(t + 1) != addr && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        string hello;
        int    budget;
        hello = "HELLO";
        init_cmd[0] = (ROWS > 1) ? 8'h38 : 8'h30;
        init_cmd[1] = 8'h0C;
        init_cmd[2] = 8'h06;
        init_cmd[3] = 8'h01;
        model_reset();

        // Power-up reset, then init sequence with buffer writes during init.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        t     = 0;
        for (int i = 0; i < 5; i++) write_char(i, hello[i]);
        write_char(16, "A");
        run(S0 * SLOT + 3 * FRAME_CLKS);

        // Scroll left through a full wrap, then right across the 0 boundary.
        scroll_en  = 1'b1;
        scroll_dir = 1'b0;
        run(34 * FRAME_CLKS);
        scroll_dir = 1'b1;
        run(4 * FRAME_CLKS);
        scroll_en = 1'b0;
        run(FRAME_CLKS);

        // Collision: write addr 2 on the edge its data slot samples it.
        wait_addr(2, "coll1");
        write_char(2, "Z");
        check("collide_old", data, "L");
        wait_addr(2, "coll2");
        step();
        check("collide_new", data, "Z");

        // Random writes and scroll settings.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                scroll_en  = 1'($urandom_range(0, 1));
                scroll_dir = 1'($urandom_range(0, 1));
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = 8'($urandom_range(32, 126));
            step();
        end
        wr_en     = 1'b0;
        scroll_en = 1'b0;

        // Async reset in the middle of row 1 characters; init must replay and the buffer clear.
        budget = 2 * FRAME_CLKS;
        while (slot_pos(t) != COLS + 1 + 5 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("midrow_timeout", 1, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        reset = 1'b0;
        t     = 0;
        run(S0 * SLOT + 2 * FRAME_CLKS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_scroll_ctrl.md
Name: lcd_scroll_ctrl

Overview:
Parametrised HD44780-style character LCD controller, 8-bit bus, write-only. Runs the power-up init sequence, then continuously refreshes ROWS x COLS characters from an internal character buffer. The buffer is loaded through a synchronous write port. Optional horizontal scrolling of the whole display, left or right, is programmable at run time. Sits between application logic (text/status producers) and the LCD pins.

Parameters:
CLK_DIV, 5, clk cycles per half period of e (slot = 2*CLK_DIV clk cycles); must be >= 1
COLS, 16, characters per row (1..20)
ROWS, 2, display rows (1..4)
POWERUP_SLOTS, 70, idle slots after reset before the first command
CLEAR_SLOTS, 20, idle slots after the clear-display command
FRAME_GAP_SLOTS, 30, idle slots between refresh frames
SCROLL_FRAMES, 50, frames per scroll step while scrolling is enabled (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  buffer write strobe, one clk per character
wr_addr  in  $clog2(ROWS*COLS)  row*COLS+col
wr_data  in  8  character code
scroll_en  in  1  1 = advance scroll offset every SCROLL_FRAMES frames
scroll_dir  in  1  0 = left (offset+1), 1 = right (offset-1)
e  out  1  LCD enable
rs  out  1  LCD register select
rw  out  1  LCD read/write (always 0 on command/data slots)
data  out  8  LCD data bus
ready  out  1  high once init has completed
frame_done  out  1  one-clk pulse at the end of each frame gap

Behaviour:
- Reset (async, high): e=0, rs=1, rw=1, data=0x00, ready=0, frame_done=0. Divider=0, offset=0, frame counter=0, all buffer bytes=0x20, state=INIT_WAIT. Asserting reset mid-frame aborts the frame and restarts the full init sequence.
- Divider: counts 0..CLK_DIV-1. On the terminal count, e toggles. A slot starts on each clk where e goes 0->1. rs, rw and data are registered in that same clk and stay stable for the whole slot. First e rise occurs CLK_DIV clks after reset release.
- Idle slot outputs: rs=1, rw=1, data=0x00.
- Command slot outputs: rs=0, rw=0.
- Data slot outputs: rs=1, rw=0.
- State sequence, one state per slot unless noted:
  - INIT_WAIT: POWERUP_SLOTS idle slots.
  - FUNC_SET: command 0x38 if ROWS>1, else 0x30.
  - DISP_ON: command 0x0C.
  - ENTRY: command 0x06.
  - CLEAR: command 0x01.
  - CLEAR_WAIT: CLEAR_SLOTS idle slots.
  - ROW_ADDR(r): command 0x80|base(r), with base = 0x00, 0x40, COLS, 0x40+COLS for r = 0..3.
  - ROW_CHARS(r): COLS data slots, c = 0..COLS-1.
  - After ROW_CHARS: go to ROW_ADDR(r+1), or to FRAME_GAP after the last row.
  - FRAME_GAP: FRAME_GAP_SLOTS idle slots, then ROW_ADDR(0).
- Frame length is ROWS*(COLS+1)+FRAME_GAP_SLOTS slots.
- ready rises in the clk of the first ROW_ADDR(0) slot and stays high until reset.
- Character sent at (r,c) is buf[r*COLS + ((c+offset) mod COLS)]. Offset width is $clog2(COLS). Wrap: left from COLS-1 goes to 0; right from 0 goes to COLS-1.
- Scroll: frame_done pulses in the clk where FRAME_GAP ends.
  - On that clk, if scroll_en=1: frame counter increments. When it reaches SCROLL_FRAMES, the counter resets to 0 and offset steps per scroll_dir, sampled on that clk.
  - If scroll_en=0: frame counter clears; offset holds its value (no snap back).
  - New offset takes effect from the next frame; offset never changes mid-frame.
- Writes: buf updated on the clk edge where wr_en=1. wr_addr >= ROWS*COLS is ignored. Writes are accepted in every state, including during init.
- Write collision: a write on the same clk that a data slot samples that location sends the old byte; the new byte appears next frame.

Test Plan:
Use CLK_DIV=2, COLS=16, ROWS=2, POWERUP_SLOTS=4, CLEAR_SLOTS=2, FRAME_GAP_SLOTS=3, SCROLL_FRAMES=2.
1. Release reset -> e period 4 clks; 4 idle slots, then rs/data = 0/0x38, 0/0x0C, 0/0x06, 0/0x01; 2 idle slots; ready rises with the 0/0x80 slot.
2. Write "HELLO" to addr 0..4 and 'A' to addr 16, no scroll -> row0 data slots H,E,L,L,O then 11x 0x20; row1 preceded by 0/0xC0 and starts with 'A'; frame_done period 37 slots.
3. scroll_en=1, dir=0 -> frames 1-2 show "HELLO..."; frame 3 row0 starts 'E' and ends 'H'; after 32 frames offset wraps to 0.
4. scroll_en=1, dir=1 from offset 0 -> after 2 frames offset=15, row0 first char = buf[15]=0x20, second = 'H'.
5. Write addr 2='Z' on the clk that samples addr 2 -> 'L' sent this frame, 'Z' next frame; write to addr 40 -> no change.
6. Assert reset mid-ROW_CHARS(1) -> outputs immediately rs=1, rw=1, data=0, e=0, ready=0; buffer all 0x20; full init replays.
